// File: rtl/pic_exec_pkg.sv
// Shared constants and types for the PIC16C57 execute sequencer.
// ALU command codes, opcode field matches, FSM state and decode bundle.
package pic_exec_pkg;

    localparam logic [7:0] ALU_APLUSB = 8'd0;
    localparam logic [7:0] ALU_ASUBB  = 8'd1;
    localparam logic [7:0] ALU_AANDB  = 8'd2;
    localparam logic [7:0] ALU_AXORA  = 8'd3;
    localparam logic [7:0] ALU_BSUB1  = 8'd4;
    localparam logic [7:0] ALU_BCOMP  = 8'd5;
    localparam logic [7:0] ALU_BPLUS1 = 8'd6;
    localparam logic [7:0] ALU_AORB   = 8'd7;
    localparam logic [7:0] ALU_BOUT   = 8'd8;
    localparam logic [7:0] ALU_AOUT   = 8'd9;
    localparam logic [7:0] ALU_RLF    = 8'd10;
    localparam logic [7:0] ALU_RRF    = 8'd11;
    localparam logic [7:0] ALU_BSUBA  = 8'd12;
    localparam logic [7:0] ALU_SWAP   = 8'd13;
    localparam logic [7:0] ALU_AXORB  = 8'd14;
    localparam logic [7:0] ALU_BCF    = 8'd15;
    localparam logic [7:0] ALU_BSF    = 8'd16;
    localparam logic [7:0] ALU_BTEST  = 8'd17;

    // inst[11:5] matches for the no-operand group
    localparam logic [6:0] OP_MISC  = 7'b0000000;
    localparam logic [6:0] OP_MOVWF = 7'b0000001;
    localparam logic [6:0] OP_CLRW  = 7'b0000010;
    localparam logic [6:0] OP_CLRF  = 7'b0000011;

    // inst[11:6] matches for byte-oriented file ops
    localparam logic [5:0] OP_SUBWF  = 6'b000010;
    localparam logic [5:0] OP_DECF   = 6'b000011;
    localparam logic [5:0] OP_IORWF  = 6'b000100;
    localparam logic [5:0] OP_ANDWF  = 6'b000101;
    localparam logic [5:0] OP_XORWF  = 6'b000110;
    localparam logic [5:0] OP_ADDWF  = 6'b000111;
    localparam logic [5:0] OP_MOVF   = 6'b001000;
    localparam logic [5:0] OP_COMF   = 6'b001001;
    localparam logic [5:0] OP_INCF   = 6'b001010;
    localparam logic [5:0] OP_DECFSZ = 6'b001011;
    localparam logic [5:0] OP_RRF    = 6'b001100;
    localparam logic [5:0] OP_RLF    = 6'b001101;
    localparam logic [5:0] OP_SWAPF  = 6'b001110;
    localparam logic [5:0] OP_INCFSZ = 6'b001111;

    // inst[11:8] matches for bit ops and literal ops
    localparam logic [3:0] OP_BCF   = 4'b0100;
    localparam logic [3:0] OP_BSF   = 4'b0101;
    localparam logic [3:0] OP_BTFSC = 4'b0110;
    localparam logic [3:0] OP_BTFSS = 4'b0111;
    localparam logic [3:0] OP_MOVLW = 4'b1100;
    localparam logic [3:0] OP_IORLW = 4'b1101;
    localparam logic [3:0] OP_ANDLW = 4'b1110;
    localparam logic [3:0] OP_XORLW = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_e;
    typedef enum logic [1:0] {A_W, A_LIT, A_BIT} asel_e;
    typedef enum logic [1:0] {DEST_NONE, DEST_W, DEST_FILE} dest_e;
    typedef enum logic [1:0] {
        SKIP_NONE, SKIP_ZERO, SKIP_BITCLR, SKIP_BITSET
    } skip_e;

    typedef struct packed {
        logic c;
        logic dc;
        logic z;
    } flag_mask_t;

    typedef struct packed {
        logic [7:0] cmd;
        asel_e      a_sel;
        logic       b_file;
        dest_e      dest;
        logic       needs_read;
        logic       needs_exec;
        flag_mask_t flags;
        skip_e      skip;
        logic       unhandled;
    } dec_t;

endpackage

// File: rtl/pic_exec_ctrl_decode.sv
// Combinational instruction decoder for the execute sequencer.
// Maps a 12-bit instruction to ALU command, operand/destination selects.
module pic_inst_decode
    import pic_exec_pkg::*;
(
    input  logic [11:0] inst,
    output dec_t        dec
);

    logic file_op;
    logic bit_op;
    logic lit_op;

    always_comb begin
        dec     = '0;
        file_op = 1'b0;
        bit_op  = 1'b0;
        lit_op  = 1'b0;
        unique case (1'b1)
            inst[11:5] == OP_MISC:  dec.unhandled = |inst[4:0];
            inst[11:5] == OP_MOVWF: begin
                dec.cmd        = ALU_AOUT;
                dec.needs_exec = 1'b1;
                dec.dest       = DEST_FILE;
            end
            inst[11:5] == OP_CLRW: begin
                dec.cmd        = ALU_AXORA;
                dec.needs_exec = 1'b1;
                dec.dest       = DEST_W;
                dec.flags      = 3'b001;
            end
            inst[11:5] == OP_CLRF: begin
                dec.cmd        = ALU_AXORA;
                dec.needs_exec = 1'b1;
                dec.dest       = DEST_FILE;
                dec.flags      = 3'b001;
            end
            inst[11:6] == OP_SUBWF: begin
                file_op = 1'b1; dec.cmd = ALU_BSUBA; dec.flags = 3'b111;
            end
            inst[11:6] == OP_DECF: begin
                file_op = 1'b1; dec.cmd = ALU_BSUB1; dec.flags = 3'b001;
            end
            inst[11:6] == OP_IORWF: begin
                file_op = 1'b1; dec.cmd = ALU_AORB; dec.flags = 3'b001;
            end
            inst[11:6] == OP_ANDWF: begin
                file_op = 1'b1; dec.cmd = ALU_AANDB; dec.flags = 3'b001;
            end
            inst[11:6] == OP_XORWF: begin
                file_op = 1'b1; dec.cmd = ALU_AXORB; dec.flags = 3'b001;
            end
            inst[11:6] == OP_ADDWF: begin
                file_op = 1'b1; dec.cmd = ALU_APLUSB; dec.flags = 3'b111;
            end
            inst[11:6] == OP_MOVF: begin
                file_op = 1'b1; dec.cmd = ALU_BOUT; dec.flags = 3'b001;
            end
            inst[11:6] == OP_COMF: begin
                file_op = 1'b1; dec.cmd = ALU_BCOMP; dec.flags = 3'b001;
            end
            inst[11:6] == OP_INCF: begin
                file_op = 1'b1; dec.cmd = ALU_BPLUS1; dec.flags = 3'b001;
            end
            inst[11:6] == OP_DECFSZ: begin
                file_op = 1'b1; dec.cmd = ALU_BSUB1; dec.skip = SKIP_ZERO;
            end
            inst[11:6] == OP_RRF: begin
                file_op = 1'b1; dec.cmd = ALU_RRF; dec.flags = 3'b100;
            end
            inst[11:6] == OP_RLF: begin
                file_op = 1'b1; dec.cmd = ALU_RLF; dec.flags = 3'b100;
            end
            inst[11:6] == OP_SWAPF: begin
                file_op = 1'b1; dec.cmd = ALU_SWAP;
            end
            inst[11:6] == OP_INCFSZ: begin
                file_op = 1'b1; dec.cmd = ALU_BPLUS1; dec.skip = SKIP_ZERO;
            end
            inst[11:8] == OP_BCF: begin
                bit_op = 1'b1; dec.cmd = ALU_BCF; dec.dest = DEST_FILE;
            end
            inst[11:8] == OP_BSF: begin
                bit_op = 1'b1; dec.cmd = ALU_BSF; dec.dest = DEST_FILE;
            end
            inst[11:8] == OP_BTFSC: begin
                bit_op = 1'b1; dec.cmd = ALU_BTEST; dec.skip = SKIP_BITCLR;
            end
            inst[11:8] == OP_BTFSS: begin
                bit_op = 1'b1; dec.cmd = ALU_BTEST; dec.skip = SKIP_BITSET;
            end
            inst[11:8] == OP_MOVLW: begin
                lit_op = 1'b1; dec.cmd = ALU_AOUT;
            end
            inst[11:8] == OP_IORLW: begin
                lit_op = 1'b1; dec.cmd = ALU_AORB; dec.flags = 3'b001;
            end
            inst[11:8] == OP_ANDLW: begin
                lit_op = 1'b1; dec.cmd = ALU_AANDB; dec.flags = 3'b001;
            end
            inst[11:8] == OP_XORLW: begin
                lit_op = 1'b1; dec.cmd = ALU_AXORB; dec.flags = 3'b001;
            end
            default: dec.unhandled = 1'b1;
        endcase
        if (file_op || bit_op) begin
            dec.needs_read = 1'b1;
            dec.needs_exec = 1'b1;
            dec.b_file     = 1'b1;
        end
        if (file_op) dec.dest = inst[5] ? DEST_FILE : DEST_W;
        if (bit_op) dec.a_sel = A_BIT;
        if (lit_op) begin
            dec.needs_exec = 1'b1;
            dec.a_sel      = A_LIT;
            dec.dest       = DEST_W;
        end
    end

endmodule

// File: rtl/pic_exec_ctrl.sv
// Multi-cycle execute sequencer for the PIC16C57 core.
// Owns W and the C/DC/Z flags; drives the shared ALU and file port.
module pic_exec_ctrl
    import pic_exec_pkg::*;
#(
    parameter logic [7:0] W_RESET = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [11:0] inst,
    output logic        rf_re,
    output logic [4:0]  rf_addr,
    input  logic [7:0]  rf_rdata,
    output logic        rf_we,
    output logic [7:0]  rf_wdata,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [7:0]  alu_cmd,
    output logic        alu_cin,
    input  logic [7:0]  alu_out,
    input  logic        alu_z,
    input  logic        alu_dc,
    input  logic        alu_c,
    input  logic        alu_test,
    output logic [7:0]  w_q,
    output logic        flag_c,
    output logic        flag_dc,
    output logic        flag_z,
    output logic        done,
    output logic        skip,
    output logic        unhandled
);

    state_e      state_q, state_d;
    logic [11:0] inst_q;
    logic [11:0] dec_inst;
    dec_t        dec;
    logic [7:0]  res_q;
    logic        z_q, dc_q, c_q, test_q;

    // In IDLE the incoming word is decoded to pick the first state
    assign dec_inst = (state_q == S_IDLE) ? inst : inst_q;

    pic_inst_decode u_dec (
        .inst (dec_inst),
        .dec  (dec)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:
                if (inst_valid) begin
                    if (dec.needs_read)      state_d = S_READ;
                    else if (dec.needs_exec) state_d = S_EXEC;
                    else                     state_d = S_WRITE;
                end
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        inst_ready = (state_q == S_IDLE);
        rf_re      = (state_q == S_READ);
        rf_addr    = inst_q[4:0];
        rf_we      = (state_q == S_WRITE) && (dec.dest == DEST_FILE);
        rf_wdata   = res_q;
        alu_cin    = flag_c;
        alu_a      = '0;
        alu_b      = '0;
        alu_cmd    = '0;
        done       = (state_q == S_WRITE);
        skip       = 1'b0;
        unhandled  = done & dec.unhandled;
        if (state_q == S_EXEC) begin
            alu_cmd = dec.cmd;
            unique case (dec.a_sel)
                A_LIT:   alu_a = inst_q[7:0];
                A_BIT:   alu_a = {5'b0, inst_q[7:5]};
                default: alu_a = w_q;
            endcase
            alu_b = dec.b_file ? rf_rdata : w_q;
        end
        if (done) begin
            unique case (dec.skip)
                SKIP_ZERO:   skip = z_q;
                SKIP_BITCLR: skip = test_q;
                SKIP_BITSET: skip = ~test_q;
                default:     skip = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            inst_q  <= '0;
            res_q   <= '0;
            z_q     <= 1'b0;
            dc_q    <= 1'b0;
            c_q     <= 1'b0;
            test_q  <= 1'b0;
            w_q     <= W_RESET;
            flag_c  <= 1'b0;
            flag_dc <= 1'b0;
            flag_z  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && inst_valid) inst_q <= inst;
            if (state_q == S_EXEC) begin
                res_q  <= alu_out;
                z_q    <= alu_z;
                dc_q   <= alu_dc;
                c_q    <= alu_c;
                test_q <= alu_test;
            end
            if (state_q == S_WRITE) begin
                if (dec.dest == DEST_W) w_q <= res_q;
                if (dec.flags.c)  flag_c  <= c_q;
                if (dec.flags.dc) flag_dc <= dc_q;
                if (dec.flags.z)  flag_z  <= z_q;
            end
        end
    end

endmodule

// File: tb/tb_pic_exec_ctrl.sv
// Directed bench for pic_exec_ctrl with a behavioural ALU and file model.
// Vector table for instruction results plus a mid-instruction reset case.
module tb_pic_exec_ctrl;
    import pic_exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic [11:0] inst = 12'h000;
    logic        rf_re;
    logic [4:0]  rf_addr;
    logic [7:0]  rf_rdata = 8'h00;
    logic        rf_we;
    logic [7:0]  rf_wdata;
    logic [7:0]  alu_a, alu_b, alu_cmd;
    logic        alu_cin;
    logic [7:0]  alu_out;
    logic        alu_z, alu_dc, alu_c, alu_test;
    logic [7:0]  w_q;
    logic        flag_c, flag_dc, flag_z;
    logic        done, skip, unhandled;

    logic        tb_we = 1'b0;
    logic [4:0]  tb_addr = 5'd0;
    logic [7:0]  tb_val = 8'h00;
    logic [7:0]  mem [32];

    int n_tests = 0;
    int n_fail  = 0;

    pic_exec_ctrl #(.W_RESET(8'h5A)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .rf_re(rf_re), .rf_addr(rf_addr), .rf_rdata(rf_rdata),
        .rf_we(rf_we), .rf_wdata(rf_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_z(alu_z), .alu_dc(alu_dc), .alu_c(alu_c),
        .alu_test(alu_test),
        .w_q(w_q), .flag_c(flag_c), .flag_dc(flag_dc), .flag_z(flag_z),
        .done(done), .skip(skip), .unhandled(unhandled)
    );

    always #5 clk = ~clk;

    // File register model: read data appears the cycle after rf_re
    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_val;
        else if (rf_we) mem[rf_addr] <= rf_wdata;
        if (rf_re) rf_rdata <= mem[rf_addr];
    end

    // Behavioural ALU, PIC semantics (C = no borrow on subtract)
    always_comb begin
        logic [8:0] s;
        logic [7:0] m;
        s        = '0;
        m        = 8'd1 << alu_a[2:0];
        alu_out  = '0;
        alu_c    = 1'b0;
        alu_dc   = 1'b0;
        alu_test = 1'b0;
        case (alu_cmd)
            ALU_APLUSB: begin
                s       = {1'b0, alu_a} + {1'b0, alu_b};
                alu_out = s[7:0];
                alu_c   = s[8];
                alu_dc  = ({1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]}) > 5'h0F;
            end
            ALU_BSUBA: begin
                alu_out = alu_b - alu_a;
                alu_c   = alu_b >= alu_a;
                alu_dc  = alu_b[3:0] >= alu_a[3:0];
            end
            ALU_AANDB:  alu_out = alu_a & alu_b;
            ALU_AORB:   alu_out = alu_a | alu_b;
            ALU_AXORB:  alu_out = alu_a ^ alu_b;
            ALU_AXORA:  alu_out = 8'h00;
            ALU_BSUB1:  alu_out = alu_b - 8'd1;
            ALU_BPLUS1: alu_out = alu_b + 8'd1;
            ALU_BCOMP:  alu_out = ~alu_b;
            ALU_BOUT:   alu_out = alu_b;
            ALU_AOUT:   alu_out = alu_a;
            ALU_RLF: begin
                alu_out = {alu_b[6:0], alu_cin};
                alu_c   = alu_b[7];
            end
            ALU_RRF: begin
                alu_out = {alu_cin, alu_b[7:1]};
                alu_c   = alu_b[0];
            end
            ALU_SWAP:   alu_out = {alu_b[3:0], alu_b[7:4]};
            ALU_BCF:    alu_out = alu_b & ~m;
            ALU_BSF:    alu_out = alu_b | m;
            ALU_BTEST:  alu_test = (alu_b & m) == 8'h00;
            default:    alu_out = 8'h00;
        endcase
        alu_z = (alu_out == 8'h00);
    end

    typedef struct {
        logic [11:0] ins;
        logic        pre_en;
        logic [4:0]  pre_addr;
        logic [7:0]  pre_val;
        logic [7:0]  exp_w;
        logic [2:0]  exp_cdz;
        logic        exp_skip;
        logic        exp_unh;
        int          exp_lat;
        logic        exp_we;
        logic        chk_file;
        logic [7:0]  exp_file;
    } vec_t;

    vec_t v [21];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a; tb_val = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic run(input logic [11:0] i, output int lat,
                       output bit saw_we, output bit sk, output bit un,
                       output bit busy_ok);
        lat = 99; saw_we = 0; sk = 0; un = 0; busy_ok = 1;
        @(negedge clk);
        inst = i; inst_valid = 1'b1;
        @(posedge clk);
        #1 inst_valid = 1'b0;
        inst = 12'hC77;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (inst_ready) busy_ok = 0;
            if (rf_we) saw_we = 1;
            if (done) begin
                lat = c; sk = skip; un = unhandled;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        bit we, sk, un, bz;
        string t;

        v[0]  = '{12'hC0F, 0, 0, 8'h00, 8'h0F, 3'b000, 0, 0, 2, 0, 0, 8'h00};
        v[1]  = '{12'h1E5, 1, 5, 8'hF1, 8'h0F, 3'b111, 0, 0, 3, 1, 1, 8'h00};
        v[2]  = '{12'hCA5, 0, 0, 8'h00, 8'hA5, 3'b111, 0, 0, 2, 0, 0, 8'h00};
        v[3]  = '{12'hFA5, 0, 0, 8'h00, 8'h00, 3'b111, 0, 0, 2, 0, 0, 8'h00};
        v[4]  = '{12'h2E7, 1, 7, 8'h01, 8'h00, 3'b111, 1, 0, 3, 1, 1, 8'h00};
        v[5]  = '{12'h2E7, 1, 7, 8'h02, 8'h00, 3'b111, 0, 0, 3, 1, 1, 8'h01};
        v[6]  = '{12'h789, 1, 9, 8'h10, 8'h00, 3'b111, 1, 0, 3, 0, 1, 8'h10};
        v[7]  = '{12'h689, 0, 0, 8'h00, 8'h00, 3'b111, 0, 0, 3, 0, 1, 8'h10};
        v[8]  = '{12'h342, 1, 2, 8'h80, 8'h01, 3'b111, 0, 0, 3, 0, 1, 8'h80};
        v[9]  = '{12'hD00, 0, 0, 8'h00, 8'h01, 3'b110, 0, 0, 2, 0, 0, 8'h00};
        v[10] = '{12'hEF0, 0, 0, 8'h00, 8'h00, 3'b111, 0, 0, 2, 0, 0, 8'h00};
        v[11] = '{12'hC05, 0, 0, 8'h00, 8'h05, 3'b111, 0, 0, 2, 0, 0, 8'h00};
        v[12] = '{12'h08A, 1, 10, 8'h03, 8'hFE, 3'b000, 0, 0, 3, 0, 1, 8'h03};
        v[13] = '{12'h06A, 0, 0, 8'h00, 8'hFE, 3'b001, 0, 0, 2, 1, 1, 8'h00};
        v[14] = '{12'h02B, 0, 0, 8'h00, 8'hFE, 3'b001, 0, 0, 2, 1, 1, 8'hFE};
        v[15] = '{12'hA12, 0, 0, 8'h00, 8'hFE, 3'b001, 0, 1, 1, 0, 0, 8'h00};
        v[16] = '{12'h000, 0, 0, 8'h00, 8'hFE, 3'b001, 0, 0, 1, 0, 0, 8'h00};
        v[17] = '{12'h040, 0, 0, 8'h00, 8'h00, 3'b001, 0, 0, 2, 0, 0, 8'h00};
        v[18] = '{12'h322, 0, 0, 8'h00, 8'h00, 3'b001, 0, 0, 3, 1, 1, 8'h40};
        v[19] = '{12'h502, 0, 0, 8'h00, 8'h00, 3'b001, 0, 0, 3, 1, 1, 8'h41};
        v[20] = '{12'h3ED, 1, 13, 8'hFF, 8'h00, 3'b001, 1, 0, 3, 1, 1, 8'h00};

        repeat (2) @(negedge clk);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_we", {31'b0, rf_we}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_w", {24'b0, w_q}, 32'h5A);
        chk("rst_flags", {29'b0, flag_c, flag_dc, flag_z}, 32'd0);
        chk("rst_ready", {31'b0, inst_ready}, 32'd1);
        chk("rst_cmd", {24'b0, alu_cmd}, 32'd0);

        for (int k = 0; k < 21; k++) begin
            if (v[k].pre_en) preload(v[k].pre_addr, v[k].pre_val);
            run(v[k].ins, lat, we, sk, un, bz);
            t = $sformatf("v%0d_%03h", k, v[k].ins);
            chk({t, "_lat"}, lat, v[k].exp_lat);
            chk({t, "_w"}, {24'b0, w_q}, {24'b0, v[k].exp_w});
            chk({t, "_cdz"}, {29'b0, flag_c, flag_dc, flag_z},
                {29'b0, v[k].exp_cdz});
            chk({t, "_skip"}, {31'b0, sk}, {31'b0, v[k].exp_skip});
            chk({t, "_unh"}, {31'b0, un}, {31'b0, v[k].exp_unh});
            chk({t, "_we"}, {31'b0, we}, {31'b0, v[k].exp_we});
            chk({t, "_busy"}, {31'b0, bz}, 32'd1);
            if (v[k].chk_file)
                chk({t, "_file"}, {24'b0, mem[v[k].ins[4:0]]},
                    {24'b0, v[k].exp_file});
        end

        // Reset asserted during EXEC of ADDWF abandons the instruction
        run(12'hC33, lat, we, sk, un, bz);
        chk("pre_rst_w", {24'b0, w_q}, 32'h33);
        preload(5'd5, 8'hF1);
        @(negedge clk);
        inst = 12'h1E5; inst_valid = 1'b1;
        @(posedge clk);
        #1 inst_valid = 1'b0;
        @(negedge clk);
        chk("read_re", {31'b0, rf_re}, 32'd1);
        chk("read_addr", {27'b0, rf_addr}, 32'd5);
        @(negedge clk);
        chk("exec_a", {24'b0, alu_a}, 32'h33);
        chk("exec_b", {24'b0, alu_b}, 32'hF1);
        chk("exec_cmd", {24'b0, alu_cmd}, {24'b0, ALU_APLUSB});
        rst_n = 1'b0;
        #1;
        chk("mid_rst_w", {24'b0, w_q}, 32'h5A);
        chk("mid_rst_flags", {29'b0, flag_c, flag_dc, flag_z}, 32'd0);
        chk("mid_rst_we", {31'b0, rf_we}, 32'd0);
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        we = 0;
        repeat (2) begin
            @(negedge clk);
            if (rf_we) we = 1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, inst_ready}, 32'd1);
        chk("post_rst_nowe", {31'b0, we}, 32'd0);
        chk("post_rst_file", {24'b0, mem[5]}, 32'hF1);
        chk("post_rst_w", {24'b0, w_q}, 32'h5A);

        // Back-to-back accept the cycle after done
        run(12'hC3C, lat, we, sk, un, bz);
        chk("after_rst_lat", lat, 2);
        chk("after_rst_w", {24'b0, w_q}, 32'h3C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pic_exec_ctrl.md
# pic_exec_ctrl

Multi-cycle execute sequencer for the PIC16C57 core. It accepts one 12-bit instruction at a time, reads the file-register operand, drives the shared 8-bit ALU with the correct command and operands, and writes the result back to W or the file. It also updates the C/DC/Z flags and reports skip conditions to the fetch/PC unit. It sits between the fetch stage, the register file and the combinational ALU; it owns W and the flag bits.

## Interface
Parameters:
- `W_RESET`, 8'h00, reset value of W.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `inst_valid`  in  1  instruction present.
- `inst_ready`  out  1  high only in IDLE; transfer on `inst_valid & inst_ready`.
- `inst`  in  12  instruction word.
- `rf_re`  out  1  file read strobe.
- `rf_addr`  out  5  file address (inst[4:0] latched).
- `rf_rdata`  in  8  read data, valid the cycle after `rf_re`.
- `rf_we`  out  1  file write strobe.
- `rf_wdata`  out  8  write data.
- `alu_a`, `alu_b`  out  8 each  ALU operands.
- `alu_cmd`  out  8  ALU command code.
- `alu_cin`  out  1  equals flag C.
- `alu_out`  in  8  ALU result.
- `alu_z`, `alu_dc`, `alu_c`, `alu_test`  in  1 each  ALU flags; `alu_test` is high when the selected bit is 0.
- `w_q`  out  8  W register.
- `flag_c`, `flag_dc`, `flag_z`  out  1 each  architectural flags.
- `done`  out  1  one-cycle pulse when the instruction retires.
- `skip`  out  1  valid with `done`: skip the next instruction.
- `unhandled`  out  1  valid with `done`: opcode not executed here.

## Operation
- Latch `inst` on accept. Destination bit is inst[5]: 0 writes W, 1 writes file. Bit index is inst[7:5]. Literal is inst[7:0].
- File operations (SUBWF, DECF, IORWF, ANDWF, XORWF, ADDWF, MOVF, COMF, INCF, DECFSZ, RRF, RLF, SWAPF, INCFSZ, BCF, BSF, BTFSC, BTFSS): drive A = W and B = `rf_rdata`.
- ALU command per opcode:
  - ADDWF → AplusB (0).
  - SUBWF → BsubA (12).
  - DECF and DECFSZ → Bsub1 (4).
  - INCF and INCFSZ → Bplus1 (6).
  - COMF → Bcomp (5).
  - IORWF → AorB (7).
  - ANDWF → AandB (2).
  - XORWF → AxorB (14).
  - MOVF → Bout (8).
  - RRF → 11; RLF → 10; SWAPF → 13.
  - BCF → 15; BSF → 16; BTFSC and BTFSS → BTest (17). For these four, A = {5'b0, bit index}.
- No file read is needed for these:
  - MOVWF → Aout, write file.
  - CLRF → AxorA, write file.
  - CLRW → AxorA, write W.
  - MOVLW, IORLW, ANDLW, XORLW: A = literal, B = W, commands Aout / AorB / AandB / AxorB, write W.
- Flag update at WRITE (only the listed flags change):
  - ADDWF, SUBWF: C, DC, Z.
  - RRF, RLF: C.
  - DECF, INCF, COMF, MOVF, IORWF, ANDWF, XORWF, CLRF, CLRW, IORLW, ANDLW, XORLW: Z.
  - All others: none.
- C and DC are taken from the ALU unmodified.
- Skip rules:
  - DECFSZ and INCFSZ: skip = registered `alu_z`.
  - BTFSC: skip = registered `alu_test`.
  - BTFSS: skip = registered ~`alu_test`.
- NOP, and any opcode not listed above (OPTION, SLEEP, CLRWDT, TRIS, RETLW, CALL, GOTO): no state change; `done` with `unhandled` = 1 for every such opcode except NOP.

## Timing
- FSM: IDLE → READ → EXEC → WRITE → IDLE for file reads; IDLE → EXEC → WRITE for no-read operations; IDLE → WRITE for NOP and unhandled opcodes.
- READ: `rf_re` = 1 and `rf_addr` driven.
- EXEC: ALU inputs driven; `alu_out` and ALU flags are registered at the end of the cycle. `rf_rdata` is sampled only in EXEC.
- WRITE: `rf_we` or W update, flag update, `done` = 1.
- Latency from the accept edge to `done`: 3 cycles for file reads, 2 for no-read operations, 1 for NOP/unhandled. Next accept is possible the cycle after `done`.
- `inst_ready` = 0 outside IDLE; `inst` is ignored there.
- Reset (asynchronous, at any time including mid-instruction):
  - State goes to IDLE and the in-flight instruction is abandoned, with no write or flag change.
  - `w_q` = `W_RESET`, all flags = 0.
  - `rf_re`, `rf_we`, `done`, `skip`, `unhandled` = 0; `alu_cmd` = 0; `inst_ready` = 1 once reset is released.
- `rf_we` and the W update are mutually exclusive. The flag update and the write happen in the same cycle.
- When a file write targets the STATUS address (5'h03), the flag update from the same instruction still takes place in this block. Resolving the two copies of STATUS is the integration's responsibility.

## Structure
- Package `pic_exec_pkg` holds:
  - ALU command constants 0–17.
  - Opcode match constants.
  - FSM state typedef.
  - Flag-mask typedef {C, DC, Z}.
  - Skip-kind typedef {NONE, ZERO, BITCLR, BITSET}.
- Sub-module `pic_inst_decode`, purely combinational: inst → `alu_cmd`, operand selects, destination, needs_read, flag mask, skip kind, unhandled. The FSM and registers stay in `pic_exec_ctrl`.

## Test plan
- W = 8'h0F; ADDWF f=5 (holds 8'hF1), d=1 → file 5 = 8'h00; C = 1, DC = 1, Z = 1; `done` 3 cycles after accept.
- MOVLW 8'hA5, then XORLW 8'hA5 → W = 8'hA5, then W = 8'h00 with Z = 1; each `done` 2 cycles after its accept.
- File 7 = 8'h01; DECFSZ f=7, d=1 → file 7 = 8'h00, `skip` = 1; repeat with 8'h02 → 8'h01, `skip` = 0.
- File 9 = 8'h10; BTFSS bit 4 → `skip` = 1; BTFSC bit 4 → `skip` = 0; no `rf_we` and flags unchanged.
- RLF with C = 1 on file 2 = 8'h80, d=0 → W = 8'h01, C = 1, file 2 unchanged.
- GOTO opcode → `done` with `unhandled` = 1 one cycle after accept. Separately, assert `rst_n` low during EXEC of ADDWF → no `rf_we`, W = `W_RESET`, `inst_ready` = 1 after release.
